// File: rtl/dsp_mac_pipe_if.sv
// Operand/result handshake bundle for dsp_mac_pipe: valid/ready on the
// operand side, valid/ready on the result side.
interface dsp_mac_pipe_if #(
  parameter int AW = 18,
  parameter int BW = 18,
  parameter int PW = 48
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [AW-1:0] a;
  logic signed [BW-1:0] b;
  logic signed [BW-1:0] d;
  logic signed [PW-1:0] c;
  logic [2:0]           op;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [PW-1:0] p;
  logic                 carryout;
  logic                 ovf;

  modport master (
    output in_valid, a, b, d, c, op, out_ready,
    input  in_ready, out_valid, p, carryout, ovf
  );

  modport slave (
    input  in_valid, a, b, d, c, op, out_ready,
    output in_ready, out_valid, p, carryout, ovf
  );
endinterface

// File: rtl/dsp_mac_pipe.sv
// Three-stage pre-add / multiply / post-add MAC with a registered accumulator,
// optional saturation and a single global stall driven by the result handshake.
module dsp_mac_pipe #(
  parameter int AW        = 18,
  parameter int BW        = 18,
  parameter int PW        = 48,
  parameter int PREADD_EN = 1,
  parameter int SAT_EN    = 1
) (
  input logic          clk,
  input logic          rstn,
  dsp_mac_pipe_if.slave bus
);
  localparam int MW = AW + BW + 1;
  localparam logic [PW-1:0] P_MAX = {1'b0, {(PW-1){1'b1}}};
  localparam logic [PW-1:0] P_MIN = {1'b1, {(PW-1){1'b0}}};

  typedef enum logic [1:0] {
    POST_M   = 2'b00,
    POST_CM  = 2'b01,
    POST_ACC = 2'b10,
    POST_SUB = 2'b11
  } post_op_e;

  logic stall;
  logic adv;

  logic                 s1_valid;
  logic signed [AW-1:0] s1_a;
  logic signed [BW:0]   s1_pre;
  logic [PW-1:0]        s1_c;
  post_op_e             s1_op;

  logic                 s2_valid;
  logic [PW-1:0]        s2_m;
  logic [PW-1:0]        s2_c;
  post_op_e             s2_op;

  logic                 out_valid_q;
  logic [PW-1:0]        p_q;
  logic                 co_q;
  logic                 ovf_q;

  // Whole pipe freezes while a result waits for the consumer.
  assign stall        = out_valid_q & ~bus.out_ready;
  assign adv          = ~stall;
  assign bus.in_ready = rstn & adv;

  logic signed [BW:0] b_ext;
  logic signed [BW:0] d_ext;
  logic signed [BW:0] pre;

  assign b_ext = {bus.b[BW-1], bus.b};
  assign d_ext = {bus.d[BW-1], bus.d};

  generate
    if (PREADD_EN != 0) begin : g_preadd
      assign pre = bus.op[2] ? (d_ext - b_ext) : (d_ext + b_ext);
    end else begin : g_no_preadd
      assign pre = b_ext;
    end
  endgenerate

  // Both operands widened to the full product width so the multiply is exact.
  logic signed [MW-1:0] a_mx;
  logic signed [MW-1:0] pre_mx;
  logic signed [MW-1:0] m;

  assign a_mx   = {{(MW-AW){s1_a[AW-1]}}, s1_a};
  assign pre_mx = {{(MW-BW-1){s1_pre[BW]}}, s1_pre};
  assign m      = a_mx * pre_mx;

  logic [PW-1:0] x;
  logic [PW-1:0] y;
  logic          cin;
  logic [PW:0]   usum;
  logic [PW:0]   exact;
  logic          co_n;
  logic          ovf_n;
  logic [PW-1:0] p_n;

  // Subtract is x + ~m + 1; the sign-extended copy of the same sum is the
  // exact result, so its top two bits disagree exactly on overflow.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    x   = '0;
    y   = s2_m;
    cin = 1'b0;
    case (s2_op)
      POST_CM:  x = s2_c;
      POST_ACC: x = p_q;
      POST_SUB: begin
        x   = p_q;
        y   = ~s2_m;
        cin = 1'b1;
      end
      default:  x = '0;
    endcase
    usum  = {1'b0, x} + {1'b0, y} + {{PW{1'b0}}, cin};
    exact = {x[PW-1], x} + {y[PW-1], y} + {{PW{1'b0}}, cin};
    co_n  = (s2_op == POST_M) ? 1'b0 : usum[PW];
    ovf_n = exact[PW] ^ exact[PW-1];
    p_n   = exact[PW-1:0];
    if (ovf_n && (SAT_EN != 0)) begin
      p_n = exact[PW] ? P_MIN : P_MAX;
    end
  end

  // NOTE: all pipeline state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid    <= 1'b0;
      s1_a        <= '0;
      s1_pre      <= '0;
      s1_c        <= '0;
      s1_op       <= POST_M;
      s2_valid    <= 1'b0;
      s2_m        <= '0;
      s2_c        <= '0;
      s2_op       <= POST_M;
      out_valid_q <= 1'b0;
      p_q         <= '0;
      co_q        <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (adv) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_a   <= bus.a;
        s1_pre <= pre;
        s1_c   <= bus.c;
        s1_op  <= post_op_e'(bus.op[1:0]);
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_m  <= {{(PW-MW){m[MW-1]}}, m};
        s2_c  <= s1_c;
        s2_op <= s1_op;
      end
      // A bubble clears out_valid but leaves the result and flags in place.
      out_valid_q <= s2_valid;
      if (s2_valid) begin
        p_q   <= p_n;
        co_q  <= co_n;
        ovf_q <= ovf_n;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.p         = p_q;
  assign bus.carryout  = co_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Self-checking bench for dsp_mac_pipe: a saturating and a wrapping instance
// share stimulus and are scored against an arithmetic reference model.
module tb_dsp_mac_pipe;
  localparam int AW = 18;
  localparam int BW = 18;
  localparam int PW = 48;
  localparam longint P_MAX = (longint'(1) <<< (PW-1)) - 1;
  localparam longint P_MIN = -(longint'(1) <<< (PW-1));

  typedef struct { logic [PW-1:0] p; logic co; logic ovf; } res_t;
  typedef struct { res_t s; res_t w; } exp_t;
  typedef struct {
    logic out_valid; logic in_ready; logic out_ready;
    logic acc; logic cons; logic extra;
    res_t s; res_t w; exp_t e;
  } obs_t;

  logic clk = 1'b0;
  logic rstn;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t expq[$];
  longint acc_s = 0;
  longint acc_w = 0;

  always #5 clk = ~clk;

  dsp_mac_pipe_if #(.AW(AW), .BW(BW), .PW(PW)) bus ();
  dsp_mac_pipe_if #(.AW(AW), .BW(BW), .PW(PW)) bus_w ();

  dsp_mac_pipe #(.AW(AW), .BW(BW), .PW(PW), .PREADD_EN(1), .SAT_EN(1)) dut (
    .clk(clk), .rstn(rstn), .bus(bus.slave));
  dsp_mac_pipe #(.AW(AW), .BW(BW), .PW(PW), .PREADD_EN(1), .SAT_EN(0)) dut_w (
    .clk(clk), .rstn(rstn), .bus(bus_w.slave));

  assign bus_w.in_valid  = bus.in_valid;
  assign bus_w.a         = bus.a;
  assign bus_w.b         = bus.b;
  assign bus_w.d         = bus.d;
  assign bus_w.c         = bus.c;
  assign bus_w.op        = bus.op;
  assign bus_w.out_ready = bus.out_ready;

  // Reference: exact integer arithmetic, then range check, saturate or wrap.
  function automatic res_t model(input logic [2:0] op, input longint a, input longint b,
                                 input longint d, input longint c, input longint acc,
                                 input bit sat);
    longint pre, m, x, ex, lim;
    logic [63:0] mask, sum;
    res_t r;
    mask = (64'd1 << PW) - 64'd1;
    pre  = op[2] ? d - b : d + b;
    m    = a * pre;
    case (op[1:0])
      2'b00:   x = 0;
      2'b01:   x = c;
      default: x = acc;
    endcase
    ex    = (op[1:0] == 2'b11) ? x - m : x + m;
    r.ovf = (ex > P_MAX) || (ex < P_MIN);
    if (op[1:0] == 2'b11) sum = (64'(x) & mask) + (64'(~m) & mask) + 64'd1;
    else                  sum = (64'(x) & mask) + (64'(m) & mask);
    r.co = (op[1:0] == 2'b00) ? 1'b0 : sum[PW];
    if (r.ovf && sat) begin
      lim = (ex > 0) ? P_MAX : P_MIN;
      r.p = lim[PW-1:0];
    end else begin
      r.p = ex[PW-1:0];
    end
    return r;
  endfunction

  function automatic longint rnd_s(input int w);
    longint v;
    v = {$urandom, $urandom};
    v = v <<< (64 - w);
    return v >>> (64 - w);
  endfunction

  task automatic drive(input logic v, input logic [2:0] op, input longint a,
                       input longint b, input longint d, input longint c);
    bus.in_valid = v;
    bus.op       = op;
    bus.a        = a[AW-1:0];
    bus.b        = b[BW-1:0];
    bus.d        = d[BW-1:0];
    bus.c        = c[PW-1:0];
  endtask

  // One clock: sample at the falling edge, update the model, return after the rising edge.
  task automatic cycle(output obs_t o);
    res_t rs, rw;
    @(negedge clk);
    o.out_valid = bus.out_valid;
    o.in_ready  = bus.in_ready;
    o.out_ready = bus.out_ready;
    o.s         = '{bus.p, bus.carryout, bus.ovf};
    o.w         = '{bus_w.p, bus_w.carryout, bus_w.ovf};
    o.acc       = bus.in_valid & bus.in_ready;
    o.cons      = bus.out_valid & bus.out_ready;
    o.extra     = 1'b0;
    o.e         = '{'{'0, 1'b0, 1'b0}, '{'0, 1'b0, 1'b0}};
    if (o.cons) begin
      if (expq.size() == 0) o.extra = 1'b1;
      else                  o.e = expq.pop_front();
    end
    if (o.acc) begin
      rs = model(bus.op, $signed(bus.a), $signed(bus.b), $signed(bus.d), $signed(bus.c), acc_s, 1'b1);
      rw = model(bus.op, $signed(bus.a), $signed(bus.b), $signed(bus.d), $signed(bus.c), acc_w, 1'b0);
      acc_s = $signed(rs.p);
      acc_w = $signed(rw.p);
      expq.push_back('{rs, rw});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    drive(1'b0, 3'b000, 0, 0, 0, 0);
    bus.out_ready = 1'b1;
    #2 rstn = 1'b0;
    expq.delete();
    acc_s = 0;
    acc_w = 0;
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
  endtask

  task automatic test_reset();
    obs_t o;
    n_checks++;
    if ({bus.in_ready, bus.out_valid, bus.p, bus.carryout, bus.ovf} !== '0) begin
      n_fail++;
      $display("FAIL reset_state_sat: got rdy=%b vld=%b p=%h co=%b ovf=%b, expected all zero",
               bus.in_ready, bus.out_valid, bus.p, bus.carryout, bus.ovf);
    end
    n_checks++;
    if ({bus_w.in_ready, bus_w.out_valid, bus_w.p, bus_w.carryout, bus_w.ovf} !== '0) begin
      n_fail++;
      $display("FAIL reset_state_wrap: got rdy=%b vld=%b p=%h, expected all zero",
               bus_w.in_ready, bus_w.out_valid, bus_w.p);
    end
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    cycle(o);
    n_checks++;
    if ({o.in_ready, o.out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b, expected 1 0", o.in_ready, o.out_valid);
    end
  endtask

  task automatic test_basic();
    obs_t o;
    apply_reset();
    drive(1'b1, 3'b000, 3, 4, 5, 0);
    cycle(o);
    n_checks++;
    if (o.acc !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_accept: got %b, expected 1", o.acc);
    end
    drive(1'b0, 3'b000, 0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      cycle(o);
      n_checks++;
      if (o.out_valid !== (k == 3)) begin
        n_fail++;
        $display("FAIL basic_latency: cycle %0d got out_valid=%b, expected %b", k, o.out_valid, (k == 3));
      end
    end
    n_checks++;
    if ({o.s.p, o.s.ovf} !== {48'd27, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_result: got p=%0d ovf=%b, expected 27 0", $signed(o.s.p), o.s.ovf);
    end
  endtask

  task automatic test_accumulate();
    obs_t o;
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      if (k < 3) drive(1'b1, 3'b010, 2, 1, 1, 0);
      else       drive(1'b0, 3'b000, 0, 0, 0, 0);
      cycle(o);
      if (k >= 3) begin
        n_checks++;
        if ({o.out_valid, o.s.p} !== {1'b1, 48'(4 * (k - 2))}) begin
          n_fail++;
          $display("FAIL accum_chain: cycle %0d got vld=%b p=%0d, expected 1 %0d",
                   k, o.out_valid, $signed(o.s.p), 4 * (k - 2));
        end
      end
    end
  endtask

  task automatic test_subtract();
    obs_t o;
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      if (k == 0)      drive(1'b1, 3'b000, 1, 5, 5, 0);
      else if (k == 1) drive(1'b1, 3'b111, 1, 5, 3, 0);
      else             drive(1'b0, 3'b000, 0, 0, 0, 0);
      cycle(o);
      if (k == 3) begin
        n_checks++;
        if (o.s.p !== 48'd10) begin
          n_fail++;
          $display("FAIL sub_setup: got p=%0d, expected 10", $signed(o.s.p));
        end
      end
      if (k == 4) begin
        n_checks++;
        if ({o.out_valid, o.s.p, o.s.co, o.s.ovf} !== {1'b1, 48'd12, 1'b0, 1'b0}) begin
          n_fail++;
          $display("FAIL sub_result: got vld=%b p=%0d co=%b ovf=%b, expected 1 12 0 0",
                   o.out_valid, $signed(o.s.p), o.s.co, o.s.ovf);
        end
      end
    end
  endtask

  task automatic test_saturation();
    obs_t o;
    longint pmax_v = P_MAX;
    longint pmin_v = P_MIN;
    logic [PW-1:0] pmax, pmin;
    logic [4*(PW+2)-1:0] want [3];
    pmax = pmax_v[PW-1:0];
    pmin = pmin_v[PW-1:0];
    // {sat p, co, ovf, wrap p, co, ovf}, padded to a common width
    want[0] = {{(2*PW-2*PW){1'b0}}, {(2*PW+4){1'b0}}, pmax, 1'b0, 1'b1, pmin, 1'b0, 1'b1};
    want[1] = {{(2*PW+4){1'b0}}, pmin, 1'b1, 1'b1, pmax, 1'b1, 1'b1};
    want[2] = {{(2*PW+4){1'b0}}, pmax, 1'b0, 1'b0, pmax, 1'b0, 1'b0};
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      if (k == 0)      drive(1'b1, 3'b001, 1, 0, 1, P_MAX);
      else if (k == 1) drive(1'b1, 3'b001, 1, 0, -1, P_MIN);
      else if (k == 2) drive(1'b1, 3'b001, 1, 0, 1, P_MAX - 1);
      else             drive(1'b0, 3'b000, 0, 0, 0, 0);
      cycle(o);
      if (k >= 3) begin
        n_checks++;
        if ({{(2*PW+4){1'b0}}, o.s.p, o.s.co, o.s.ovf, o.w.p, o.w.co, o.w.ovf} !== want[k-3]) begin
          n_fail++;
          $display("FAIL saturation_%0d: got sat p=%h co=%b ovf=%b wrap p=%h co=%b ovf=%b, expected %h",
                   k - 3, o.s.p, o.s.co, o.s.ovf, o.w.p, o.w.co, o.w.ovf, want[k-3][2*PW+3:0]);
        end
      end
    end
  endtask

  task automatic test_stall();
    obs_t o;
    logic [2:0] t_op [6];
    longint t_a [6], t_b [6], t_d [6], t_c [6];
    int issued = 0;
    int got = 0;
    logic [PW-1:0] held = '0;
    for (int i = 0; i < 6; i++) begin
      t_op[i] = 3'($urandom_range(0, 7));
      t_a[i] = rnd_s(AW); t_b[i] = rnd_s(BW); t_d[i] = rnd_s(BW); t_c[i] = rnd_s(40);
    end
    apply_reset();
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      if (issued < 6) drive(1'b1, t_op[issued], t_a[issued], t_b[issued], t_d[issued], t_c[issued]);
      else            drive(1'b0, 3'b000, 0, 0, 0, 0);
      bus.out_ready = !(cyc == 4 || cyc == 5);
      cycle(o);
      if (o.acc) issued++;
      if (cyc == 4) held = o.s.p;
      if (cyc == 4 || cyc == 5) begin
        n_checks++;
        if ({o.in_ready, o.out_valid} !== 2'b01) begin
          n_fail++;
          $display("FAIL stall_ready: cycle %0d got in_ready=%b out_valid=%b, expected 0 1",
                   cyc, o.in_ready, o.out_valid);
        end
      end
      if (cyc == 5 || cyc == 6) begin
        n_checks++;
        if (o.s.p !== held) begin
          n_fail++;
          $display("FAIL stall_hold: cycle %0d got p=%h, expected %h", cyc, o.s.p, held);
        end
      end
      if (o.cons) begin
        got++;
        n_checks++;
        if (o.extra || {o.s.p, o.s.co, o.s.ovf, o.w.p, o.w.co, o.w.ovf} !==
                       {o.e.s.p, o.e.s.co, o.e.s.ovf, o.e.w.p, o.e.w.co, o.e.w.ovf}) begin
          n_fail++;
          $display("FAIL stall_result_%0d: got p=%h/%h co=%b ovf=%b extra=%b, expected p=%h/%h co=%b ovf=%b",
                   got, o.s.p, o.w.p, o.s.co, o.s.ovf, o.extra, o.e.s.p, o.e.w.p, o.e.s.co, o.e.s.ovf);
        end
      end
    end
    n_checks++;
    if ({issued, got, expq.size()} !== {32'd6, 32'd6, 32'd0}) begin
      n_fail++;
      $display("FAIL stall_count: got issued=%0d delivered=%0d pending=%0d, expected 6 6 0",
               issued, got, expq.size());
    end
    for (int k = 0; k < 4; k++) begin
      cycle(o);
      n_checks++;
      if (o.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_duplicate: got out_valid=%b, expected 0", o.out_valid);
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 3'b000, 5 + k, 1, 1, 0);
      cycle(o);
    end
    drive(1'b0, 3'b000, 0, 0, 0, 0);
    n_checks++;
    if ({bus.out_valid, bus.p} !== {1'b1, 48'd10}) begin
      n_fail++;
      $display("FAIL midreset_before: got vld=%b p=%0d, expected 1 10", bus.out_valid, $signed(bus.p));
    end
    #2 rstn = 1'b0;
    #1;
    n_checks++;
    if ({bus.p, bus.out_valid, bus.in_ready, bus_w.p, bus_w.out_valid} !== '0) begin
      n_fail++;
      $display("FAIL midreset_clear: got p=%h vld=%b rdy=%b, expected all zero",
               bus.p, bus.out_valid, bus.in_ready);
    end
    expq.delete();
    acc_s = 0;
    acc_w = 0;
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle(o);
      n_checks++;
      if (o.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_ghost: cycle %0d got out_valid=%b, expected 0", k, o.out_valid);
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (k == 0) drive(1'b1, 3'b010, 2, 1, 1, 0);
      else        drive(1'b0, 3'b000, 0, 0, 0, 0);
      cycle(o);
    end
    n_checks++;
    if ({o.out_valid, o.s.p} !== {1'b1, 48'd4}) begin
      n_fail++;
      $display("FAIL midreset_accum: got vld=%b p=%0d, expected 1 4", o.out_valid, $signed(o.s.p));
    end
  endtask

  task automatic test_random();
    obs_t o;
    longint c;
    apply_reset();
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 3))
        0:       c = P_MAX - longint'($urandom_range(0, 1 << 20));
        1:       c = P_MIN + longint'($urandom_range(0, 1 << 20));
        default: c = rnd_s(44);
      endcase
      if ($urandom_range(0, 9) < 7)
        drive(1'b1, 3'($urandom_range(0, 7)), rnd_s(AW), rnd_s(BW), rnd_s(BW), c);
      else
        drive(1'b0, 3'b000, 0, 0, 0, 0);
      bus.out_ready = ($urandom_range(0, 9) < 8);
      cycle(o);
      n_checks++;
      if (o.in_ready !== !(o.out_valid && !o.out_ready)) begin
        n_fail++;
        $display("FAIL rand_ready: cycle %0d got in_ready=%b, expected %b",
                 k, o.in_ready, !(o.out_valid && !o.out_ready));
      end
      if (o.cons) begin
        n_checks++;
        if (o.extra || {o.s.p, o.s.co, o.s.ovf, o.w.p, o.w.co, o.w.ovf} !==
                       {o.e.s.p, o.e.s.co, o.e.s.ovf, o.e.w.p, o.e.w.co, o.e.w.ovf}) begin
          n_fail++;
          $display("FAIL rand_result: cycle %0d got p=%h/%h co=%b/%b ovf=%b/%b extra=%b, expected p=%h/%h co=%b/%b ovf=%b/%b",
                   k, o.s.p, o.w.p, o.s.co, o.w.co, o.s.ovf, o.w.ovf, o.extra,
                   o.e.s.p, o.e.w.p, o.e.s.co, o.e.w.co, o.e.s.ovf, o.e.w.ovf);
        end
      end
    end
    drive(1'b0, 3'b000, 0, 0, 0, 0);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10 && expq.size() > 0; k++) begin
      cycle(o);
      if (o.cons) begin
        n_checks++;
        if (o.extra || {o.s.p, o.s.co, o.s.ovf, o.w.p, o.w.co, o.w.ovf} !==
                       {o.e.s.p, o.e.s.co, o.e.s.ovf, o.e.w.p, o.e.w.co, o.e.w.ovf}) begin
          n_fail++;
          $display("FAIL rand_drain: got p=%h/%h, expected p=%h/%h", o.s.p, o.w.p, o.e.s.p, o.e.w.p);
        end
      end
    end
    n_checks++;
    if (expq.size() !== 0) begin
      n_fail++;
      $display("FAIL rand_pending: got %0d results outstanding, expected 0", expq.size());
    end
  endtask

  initial begin
    rstn = 1'b0;
    drive(1'b0, 3'b000, 0, 0, 0, 0);
    bus.out_ready = 1'b1;
    #1;
    test_reset();
    test_basic();
    test_accumulate();
    test_subtract();
    test_saturation();
    test_stall();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
